// File: rtl/uart_baudgen.sv
// Fractional baud-rate generator: oversample, mid-bit rx sample and tx bit strobes.
// Define UART_BAUDGEN_FRAC_EN to enable the fractional divisor accumulator.
module uart_baudgen #(
  parameter int INT_W          = 16,
  parameter int FRAC_W         = 4,
  parameter int OSR            = 16,
  parameter int RESET_DIV_INT  = 27,
  parameter int RESET_DIV_FRAC = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [INT_W-1:0]  div_int,
  input  logic [FRAC_W-1:0] div_frac,
  input  logic              div_load,
  input  logic              rx_sync,
  output logic              os_tick,
  output logic              rx_sample,
  output logic              tx_tick
);

  localparam int OSR_W = $clog2(OSR);
  localparam logic [OSR_W-1:0] TX_LAST = OSR_W'(OSR - 1);
  localparam logic [OSR_W-1:0] RX_MID  = OSR_W'(OSR / 2 - 1);

  logic [INT_W-1:0] cnt_q;
  logic [INT_W-1:0] div_q;
  logic             pend_q;
  logic [INT_W-1:0] pend_int_q;
  logic [OSR_W-1:0] tx_q;
  logic [OSR_W-1:0] rx_q;
  logic             os_q;
  logic             rxs_q;
  logic             txt_q;

  logic [INT_W-1:0] per;
  logic [INT_W:0]   last;
  logic             wrap;
  logic             apply;
  logic [INT_W-1:0] nxt_int;
  logic             extra;

  // divisors below 2 run at the minimum period of 2
  assign per   = (div_q < INT_W'(2)) ? INT_W'(2) : div_q;
  assign last  = {1'b0, per} + {{INT_W{1'b0}}, extra}
               - (INT_W+1)'(1);
  assign wrap  = ({1'b0, cnt_q} == last);
  assign apply = div_load | pend_q;
  assign nxt_int = div_load ? div_int : pend_int_q;

`ifdef UART_BAUDGEN_FRAC_EN
  logic [FRAC_W-1:0] frac_q;
  logic [FRAC_W-1:0] pend_frac_q;
  logic [FRAC_W-1:0] acc_q;
  logic              extra_q;
  logic [FRAC_W-1:0] nxt_frac;
  logic [FRAC_W:0]   acc_d;

  assign extra    = extra_q;
  assign nxt_frac = div_load ? div_frac : pend_frac_q;
  assign acc_d    = {1'b0, acc_q} + {1'b0, frac_q};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frac_q      <= FRAC_W'(RESET_DIV_FRAC);
      pend_frac_q <= '0;
      acc_q       <= '0;
      extra_q     <= 1'b0;
    end else if (!en) begin
      if (div_load) begin
        frac_q  <= div_frac;
        acc_q   <= '0;
        extra_q <= 1'b0;
      end
    end else begin
      if (div_load) pend_frac_q <= div_frac;
      if (wrap) begin
        if (apply) begin
          frac_q  <= nxt_frac;
          acc_q   <= '0;
          extra_q <= 1'b0;
        end else begin
          acc_q   <= acc_d[FRAC_W-1:0];
          extra_q <= acc_d[FRAC_W];
        end
      end
    end
  end
`else
  logic unused_frac;
  assign extra       = 1'b0;
  assign unused_frac = ^div_frac;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= '0;
      div_q      <= INT_W'(RESET_DIV_INT);
      pend_q     <= 1'b0;
      pend_int_q <= '0;
      tx_q       <= '0;
      rx_q       <= '0;
      os_q       <= 1'b0;
      rxs_q      <= 1'b0;
      txt_q      <= 1'b0;
    end else begin
      os_q  <= 1'b0;
      rxs_q <= 1'b0;
      txt_q <= 1'b0;
      if (!en) begin
        if (div_load) begin
          div_q  <= div_int;
          cnt_q  <= '0;
          pend_q <= 1'b0;
        end
        if (rx_sync) rx_q <= '0;
      end else begin
        if (div_load) begin
          pend_q     <= 1'b1;
          pend_int_q <= div_int;
        end
        if (wrap) begin
          cnt_q <= '0;
          os_q  <= 1'b1;
          txt_q <= (tx_q == TX_LAST);
          tx_q  <= tx_q + OSR_W'(1);
          // a coincident sync wins over the mid-bit sample
          rxs_q <= !rx_sync && (rx_q == RX_MID);
          rx_q  <= rx_sync ? '0 : rx_q + OSR_W'(1);
          if (apply) begin
            div_q  <= nxt_int;
            pend_q <= 1'b0;
          end
        end else begin
          cnt_q <= cnt_q + INT_W'(1);
          if (rx_sync) rx_q <= '0;
        end
      end
    end
  end

  assign os_tick   = os_q;
  assign rx_sample = rxs_q;
  assign tx_tick   = txt_q;

endmodule
